rr_encode_arbiter: RTL and testbench
====================================

Name: rr_encode_arbiter

Overview:
- Round-robin arbiter that shares the 4-to-2 encoder path among N requesters.
- Registers a one-hot grant, its binary-encoded index and the index parity, so downstream logic sees one owner at a time.
- Bounds each ownership with a hold timeout so that no requester is starved.
- Sits between the requester bank and the encoder/counter datapath.

Parameters:
- N, 4, number of requesters; legal values 2, 4, 8.
- IDX_W, 2, index width; must equal log2(N).
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; bit i is held high while requester i wants the resource.
- gnt  output  N  registered one-hot grant; all zeros when idle.
- gnt_valid  output  1  high when gnt is non-zero.
- gnt_idx  output  IDX_W  binary index of the granted bit; 0 when idle.
- gnt_par  output  1  XOR of gnt_idx bits; 0 when idle.
- timeout  output  1  one-cycle pulse, asserted in the first IDLE cycle after a forced release.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, ptr=0, hold_cnt=0; gnt=0, gnt_valid=0, gnt_idx=0, gnt_par=0, timeout=0. Reset overrides everything, including mid-grant; the grant drops at that same edge.
- States: IDLE, GRANT.
- IDLE, req==0: stay in IDLE, outputs idle.
- IDLE, req!=0:
  - Winner is the first set bit searching ptr, ptr+1, ... mod N.
  - At the next edge: state=GRANT, gnt=one-hot(winner), gnt_idx=winner, gnt_par=^winner, gnt_valid=1, hold_cnt=0.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT, each edge with hold_cnt counting the grant cycles already elapsed:
  - If req[gnt_idx]==0 (voluntary release): go to IDLE and clear outputs.
  - Else if hold_cnt==MAX_HOLD-1 (forced release): go to IDLE, clear outputs, and set timeout=1 for the following cycle.
  - Else: hold_cnt++ and keep the grant.
  - On either release, ptr=(gnt_idx+1) mod N.
- Requests from other requesters during GRANT are ignored. They are arbitrated only in IDLE.
- There is always at least one IDLE cycle between consecutive grants; this is the handover gap.
- A requester that was force-released and keeps req high re-competes normally from the advanced ptr. With other requesters pending, it therefore waits its turn.
- If only one requester is active, it can be re-granted after the single gap cycle.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt_valid == |gnt.
  - gnt_idx and gnt_par are consistent with gnt.
- ptr wraps from N-1 to 0.
- hold_cnt width is 8 bits; it never exceeds MAX_HOLD-1.

Decomposition:
- Shared package/include file holds:
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - defaults N=4, IDX_W=2, MAX_HOLD=8.
- One sub-module: rr_pick. It is combinational; given req and ptr it returns winner index and a found flag. It implements the rotate-and-priority-search and is reusable by future arbiters.
- The FSM, ptr and hold counter stay in the top module.

Test Plan:
- Reset mid-grant: grant req=4'b0010; assert rst during GRANT -> at that edge all outputs 0, ptr=0. Release rst with req=4'b0011 -> gnt=4'b0001, gnt_idx=0.
- Single request: req=4'b0100 from cycle 2, dropped at cycle 5 -> gnt=4'b0100, gnt_idx=2, gnt_par=1 during cycles 3..5. IDLE at cycle 6. ptr=3.
- Round-robin fairness: req=4'b1111 held, each granted requester dropping after 2 grant cycles, then re-raising -> grant order 0,1,2,3,0, with exactly one idle gap cycle between grants.
- Timeout: req=4'b0001 held high for 20 cycles, MAX_HOLD=8 -> gnt high exactly 8 cycles, then 1 idle cycle with timeout=1, then re-grant to requester 0.
- Timeout with contention: req=4'b1001 held -> grants alternate 0 (8 cycles), 3 (8 cycles), 0, ...; timeout pulses after each ownership.
- Wrap-around and parity: force ptr=3 via prior grant to 2, then req=4'b0011 -> winner 0 (search 3,0). gnt_par=0; a later grant of 1 gives gnt_par=1.

Source files
------------

// File: rtl/rr_encode_arbiter_pkg.sv
// Shared types and defaults for the round-robin encode arbiter family.
// State encoding, parameter defaults and the index parity helper.
package rr_encode_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_IDX_W    = 2;
    localparam int DEF_MAX_HOLD = 8;
    localparam int HOLD_W       = 8;

    function automatic logic idx_parity(input logic [7:0] idx);
        return ^idx;
    endfunction

endpackage

// File: rtl/rr_encode_arbiter_if.sv
// Request/grant bundle between the requester bank and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_encode_arbiter_if
    import rr_encode_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = DEF_IDX_W
) ();

    logic [N-1:0]     req;
    logic [N-1:0]     gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_par;
    logic             timeout;

    modport master (
        output req,
        input  gnt, gnt_valid, gnt_idx, gnt_par, timeout
    );

    modport slave (
        input  req,
        output gnt, gnt_valid, gnt_idx, gnt_par, timeout
    );

endinterface

// File: rtl/rr_encode_arbiter_rr_pick.sv
// Rotating priority search: first set req bit at or after ptr, modulo N.
// Latency: combinational.
// Backpressure: none; pure function of req and ptr.
module rr_pick
    import rr_encode_arbiter_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset back to ptr so the nearest hit wins last;
    // N is a power of two, so the index addition wraps on its own.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_encode_arbiter.sv
// Round-robin arbiter with registered one-hot grant, index, parity and hold timeout.
// Latency: 1 cycle req->gnt; one idle handover cycle between any two grants.
// Backpressure: owner holds gnt while req stays high, up to MAX_HOLD cycles.
module rr_encode_arbiter
    import rr_encode_arbiter_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst,
    rr_encode_arbiter_if.slave bus
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N-1:0]      gnt_q, gnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              vld_q, vld_d;
    logic              par_q, par_d;
    logic              to_q, to_d;

    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic              own_req;
    logic              hold_last;
    logic              rel;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (win_idx),
        .found  (win_found)
    );

    assign own_req   = bus.req[idx_q];
    assign hold_last = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign rel       = (state_q == GRANT) && (!own_req || hold_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            par_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            par_q   <= par_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found) state_d = GRANT;
            GRANT:   if (rel)       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        idx_d  = '0;
        vld_d  = 1'b0;
        par_d  = 1'b0;
        to_d   = 1'b0;
        hold_d = hold_q;
        ptr_d  = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d  = N'(1) << win_idx;
                    idx_d  = win_idx;
                    vld_d  = 1'b1;
                    par_d  = idx_parity(8'(win_idx));
                    hold_d = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    // Owner still requesting at release means the hold limit forced it out.
                    ptr_d  = idx_q + IDX_W'(1);
                    hold_d = '0;
                    to_d   = own_req;
                end else begin
                    gnt_d  = gnt_q;
                    idx_d  = idx_q;
                    vld_d  = 1'b1;
                    par_d  = par_q;
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                hold_d = '0;
            end
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = vld_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_par   = par_q;
    assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_encode_arbiter.sv
// Bench for rr_encode_arbiter: directed scenarios plus random traffic,
// every cycle compared against an ownership-level reference model.
module tb_rr_encode_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rr_encode_arbiter_if #(.N(N), .IDX_W(2)) bus ();

    rr_encode_arbiter #(
        .N        (N),
        .IDX_W    (2),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the resource, for how many cycles, and where the search starts next.
    int m_owner   = -1;
    int m_held    = 0;
    int m_ptr     = 0;
    bit m_to      = 1'b0;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        logic [3:0] r;
        bit         hit;
        r = bus.req;
        if (rst) begin
            m_owner   = -1;
            m_held    = 0;
            m_ptr     = 0;
            m_to      = 1'b0;
            m_started = 1'b1;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            hit  = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (!hit && r[(m_ptr + j) % N]) begin
                    hit     = 1'b1;
                    m_owner = (m_ptr + j) % N;
                    m_held  = 1;
                end
            end
        end else begin
            m_to = 1'b0;
            if (!r[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] one, exp_gnt;
        logic [1:0] exp_idx;
        logic [8:0] act_v, exp_v;
        if (m_started) begin
            one     = 4'b0001;
            exp_gnt = (m_owner >= 0) ? (one << m_owner) : 4'b0000;
            exp_idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
            exp_v   = {exp_gnt, (m_owner >= 0), exp_idx, exp_idx[1] ^ exp_idx[0], m_to};
            act_v   = {bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.gnt_par, bus.timeout};
            check("model_cmp {gnt,vld,idx,par,to}", 32'(act_v), 32'(exp_v));
        end
    end

    // Ownership monitor for the directed literal checks.
    int         order_q[$];
    int         len_q[$];
    int         timeout_cnt = 0;
    int         cur_len     = 0;
    logic [3:0] prev_gnt    = 4'b0000;

    always @(negedge clk) begin
        if (bus.gnt != 4'b0000) begin
            if (prev_gnt == 4'b0000) begin
                order_q.push_back(int'(bus.gnt_idx));
                cur_len = 1;
            end else begin
                cur_len++;
            end
        end else if (prev_gnt != 4'b0000) begin
            len_q.push_back(cur_len);
        end
        if (bus.timeout) timeout_cnt++;
        prev_gnt = bus.gnt;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        order_q.delete();
        len_q.delete();
        timeout_cnt = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = 4'b0000;
        step(1);
        rst = 1'b0;
        clear_mon();
    endtask

    initial begin
        logic [3:0] r;
        bus.req = 4'b0000;
        rst     = 1'b1;
        step(2);
        check("reset_gnt", 32'(bus.gnt), 32'h0);
        check("reset_vld_to", 32'({bus.gnt_valid, bus.timeout}), 32'h0);

        // Reset in the middle of an ownership.
        rst     = 1'b0;
        bus.req = 4'b0010;
        step(2);
        check("mid_grant_gnt", 32'(bus.gnt), 32'b0010);
        rst = 1'b1;
        step(1);
        check("mid_reset_gnt", 32'({bus.gnt, bus.gnt_idx, bus.gnt_par}), 32'h0);
        check("model_pin_reset", 32'(m_owner), 32'hFFFF_FFFF);
        rst     = 1'b0;
        bus.req = 4'b0011;
        step(1);
        check("post_reset_gnt", 32'(bus.gnt), 32'b0001);
        check("post_reset_idx", 32'(bus.gnt_idx), 32'd0);
        bus.req = 4'b0000;
        step(2);

        // Single requester, then wrap-around from ptr=3 and parity.
        bus.req = 4'b0100;
        step(3);
        check("single_gnt", 32'(bus.gnt), 32'b0100);
        check("single_idx_par", 32'({bus.gnt_idx, bus.gnt_par}), 32'b101);
        check("model_pin_single", 32'(m_owner), 32'd2);
        bus.req = 4'b0000;
        step(1);
        check("single_idle", 32'(bus.gnt_valid), 32'd0);
        check("model_pin_ptr3", 32'(m_ptr), 32'd3);
        bus.req = 4'b0011;
        step(1);
        check("wrap_gnt", 32'(bus.gnt), 32'b0001);
        check("wrap_par", 32'(bus.gnt_par), 32'd0);
        bus.req = 4'b0010;
        step(2);
        check("par1_gnt", 32'(bus.gnt), 32'b0010);
        check("par1_par", 32'(bus.gnt_par), 32'd1);
        bus.req = 4'b0000;
        step(2);

        // Fairness: everyone requests, each owner lets go after two cycles.
        do_reset();
        for (int c = 0; c < 30; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
            bus.req = r;
            step(1);
        end
        bus.req = 4'b0000;
        step(3);
        check("fair_order_n", 32'(order_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) check($sformatf("fair_order[%0d]", i), 32'(order_q[i]), 32'(i % 4));
        for (int i = 0; i < 4; i++) check($sformatf("fair_len[%0d]", i), 32'(len_q[i]), 32'd2);

        // Lone requester hitting the hold limit.
        do_reset();
        bus.req = 4'b0001;
        step(20);
        bus.req = 4'b0000;
        step(3);
        check("to_len0", 32'(len_q[0]), 32'd8);
        check("to_len1", 32'(len_q[1]), 32'd8);
        check("to_pulses", 32'(timeout_cnt), 32'd2);
        check("to_regrant", 32'(order_q[1]), 32'd0);

        // Two contenders alternating on timeouts.
        do_reset();
        bus.req = 4'b1001;
        step(40);
        bus.req = 4'b0000;
        step(3);
        for (int i = 0; i < 4; i++) check($sformatf("cont_order[%0d]", i), 32'(order_q[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
        for (int i = 0; i < 3; i++) check($sformatf("cont_len[%0d]", i), 32'(len_q[i]), 32'd8);
        check("cont_pulses", 32'(timeout_cnt), 32'd4);

        // Random traffic with sticky requests and occasional resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) bus.req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 149) == 0);
            step(1);
        end
        rst     = 1'b0;
        bus.req = 4'b0000;
        step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
